reboot_ctrl: RTL and testbench
==============================

REBOOT_CTRL -- requirements
Module: reboot_ctrl

Interface
REQ-001 SHALL have parameter KEY, default 16'hB007; the key value that authorises a reboot.
REQ-002 SHALL have parameter DELAY, default 16'd1000; countdown cycles between request acceptance and reboot, legal range 0..65535.
REQ-003 SHALL have parameter HOLD, default 8'd32; number of cycles reboot is held high, legal range 17..255, which covers the 16-word ICAP sequence.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  1  reboot request valid.
REQ-007 SHALL have port req_key  input  16  key presented with the request.
REQ-008 SHALL have port req_ready  output  1  high only in IDLE; a request is accepted on a rising edge when req_valid and req_ready are both high.
REQ-009 SHALL have port cancel  input  1  aborts a pending countdown.
REQ-010 SHALL have port reboot  output  1  registered level driving the downstream ICAP reboot sequencer.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port remaining  output  16  current countdown value in COUNTDOWN, 0 otherwise.
REQ-013 SHALL have port bad_key_cnt  output  8  saturating count of rejected requests.
REQ-014 SHALL have port reboot_fail  output  1  sticky flag set when FIRE completes without device reconfiguration.

Function
REQ-015 SHALL implement states IDLE, COUNTDOWN, FIRE.
REQ-016 SHALL, on an accepted request with req_key==KEY in IDLE, enter COUNTDOWN at that edge with remaining=DELAY.
REQ-017 SHALL, on an accepted request with req_key!=KEY, stay in IDLE and increment bad_key_cnt, saturating at 8'hFF.
REQ-018 SHALL, in COUNTDOWN with cancel low and remaining!=0, decrement remaining by 1 each cycle.
REQ-019 SHALL, in COUNTDOWN with cancel low and remaining==0, enter FIRE on the next edge, drive reboot=1 and load an internal hold counter with HOLD-1.
REQ-020 SHALL, as a consequence of REQ-016..019, raise reboot exactly DELAY+1 edges after the acceptance edge; with DELAY=0, reboot rises one edge after acceptance.
REQ-021 SHALL hold reboot high for exactly HOLD consecutive cycles in FIRE, with no glitch or deassertion in between.
REQ-022 SHALL, when the hold counter reaches 0 in FIRE, return to IDLE on the next edge, drive reboot=0 and set reboot_fail=1.
REQ-023 SHALL, when cancel is high in COUNTDOWN, return to IDLE on the next edge with remaining=0; cancel wins over remaining==0 in the same cycle.
REQ-024 SHALL ignore cancel in FIRE and in IDLE.
REQ-025 SHALL ignore req_valid while busy (req_ready low): no state change and no bad_key_cnt change.
REQ-026 SHALL keep reboot_fail set until reset; a later successful request SHALL NOT clear it.
REQ-027 SHALL drive reboot, req_ready, busy and remaining from registers or pure state decode only, never combinationally from inputs.

Reset
REQ-028 SHALL, while rst_n is low, asynchronously force: state=IDLE, reboot=0, req_ready=1, busy=0, remaining=0, bad_key_cnt=0, reboot_fail=0, hold counter=0.
REQ-029 SHALL, on rst_n assertion mid-COUNTDOWN or mid-FIRE, drop reboot to 0 immediately, without waiting for a clock edge.
REQ-030 SHALL accept no request on the first edge after rst_n deasserts if req_valid was high during reset; acceptance resumes from the second edge.

Verification
REQ-031 SHALL cover: DELAY=4, HOLD=20, valid request with key B007 at edge T -> remaining 4,3,2,1,0; reboot high from T+5 through T+24; IDLE and reboot_fail=1 at T+25.
REQ-032 SHALL cover: request with key 1234 -> state stays IDLE, bad_key_cnt=1; 300 bad requests -> bad_key_cnt=FF.
REQ-033 SHALL cover: cancel asserted when remaining==2 -> IDLE next edge, reboot never rises, remaining=0.
REQ-034 SHALL cover: cancel asserted in the cycle where remaining==0 -> IDLE, reboot stays 0.
REQ-035 SHALL cover: rst_n pulsed low at FIRE cycle 5 -> reboot 0 immediately, all outputs at reset values, reboot_fail=0.
REQ-036 SHALL cover: DELAY=0, valid request -> reboot high on the next edge for HOLD cycles; a second request during FIRE is ignored.

Source files
------------

// File: rtl/reboot_ctrl.sv
// Keyed, cancellable reboot controller: after an authorised request it counts
// down DELAY cycles, then holds `reboot` high for HOLD cycles for the ICAP sequencer.
module reboot_ctrl #(
  parameter logic [15:0] KEY   = 16'hB007,
  parameter logic [15:0] DELAY = 16'd1000,
  parameter logic [7:0]  HOLD  = 8'd32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [15:0] req_key,
  output logic        req_ready,
  input  logic        cancel,
  output logic        reboot,
  output logic        busy,
  output logic [15:0] remaining,
  output logic [7:0]  bad_key_cnt,
  output logic        reboot_fail
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CNT  = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;

  logic [1:0] state;
  logic [7:0] hold_cnt;
  logic       armed;
  logic       accept;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  // armed is clear for the first edge after reset so a request held through reset is not taken
  assign accept    = req_valid && req_ready && armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      reboot      <= 1'b0;
      remaining   <= 16'd0;
      bad_key_cnt <= 8'd0;
      reboot_fail <= 1'b0;
      hold_cnt    <= 8'd0;
      armed       <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (req_key == KEY) begin
              state     <= S_CNT;
              remaining <= DELAY;
            end else if (bad_key_cnt != 8'hFF) begin
              bad_key_cnt <= bad_key_cnt + 8'd1;
            end
          end
        end
        S_CNT: begin
          // cancel takes priority over expiry in the same cycle
          if (cancel) begin
            state     <= S_IDLE;
            remaining <= 16'd0;
          end else if (remaining != 16'd0) begin
            remaining <= remaining - 16'd1;
          end else begin
            state    <= S_FIRE;
            reboot   <= 1'b1;
            hold_cnt <= HOLD - 8'd1;
          end
        end
        S_FIRE: begin
          // still alive after the full hold: the device did not reconfigure
          if (hold_cnt == 8'd0) begin
            state       <= S_IDLE;
            reboot      <= 1'b0;
            reboot_fail <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          reboot    <= 1'b0;
          remaining <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reboot_ctrl.sv
// Directed bench for reboot_ctrl: one instance with DELAY=4/HOLD=20, one with DELAY=0/HOLD=20.
module tb_reboot_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic        a_req_valid, a_cancel, a_req_ready, a_reboot, a_busy, a_fail;
  logic [15:0] a_req_key, a_rem;
  logic [7:0]  a_bad;
  logic        b_req_valid, b_cancel, b_req_ready, b_reboot, b_busy, b_fail;
  logic [15:0] b_req_key, b_rem;
  logic [7:0]  b_bad;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  reboot_ctrl #(.KEY(16'hB007), .DELAY(16'd4), .HOLD(8'd20)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_key(a_req_key),
    .req_ready(a_req_ready), .cancel(a_cancel), .reboot(a_reboot), .busy(a_busy),
    .remaining(a_rem), .bad_key_cnt(a_bad), .reboot_fail(a_fail));

  reboot_ctrl #(.KEY(16'hB007), .DELAY(16'd0), .HOLD(8'd20)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_key(b_req_key),
    .req_ready(b_req_ready), .cancel(b_cancel), .reboot(b_reboot), .busy(b_busy),
    .remaining(b_rem), .bad_key_cnt(b_bad), .reboot_fail(b_fail));

  task automatic push(input logic [15:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s scoreboard empty, observed=%0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic pc(input string tag, input logic [15:0] obs, input logic [15:0] v);
    push(v);
    chk(tag, obs);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic reset_vals_a();
    pc("a_rst_reboot", {15'd0, a_reboot}, 16'd0);
    pc("a_rst_ready", {15'd0, a_req_ready}, 16'd1);
    pc("a_rst_busy", {15'd0, a_busy}, 16'd0);
    pc("a_rst_rem", a_rem, 16'd0);
    pc("a_rst_bad", {8'd0, a_bad}, 16'd0);
    pc("a_rst_fail", {15'd0, a_fail}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b1; a_req_key = 16'hB007; a_cancel = 1'b0;
    b_req_valid = 1'b0; b_req_key = 16'hB007; b_cancel = 1'b0;
    repeat (2) step();
    reset_vals_a();
    pc("b_rst_ready", {15'd0, b_req_ready}, 16'd1);

    // request held through reset: first edge ignored, second edge accepts
    rst_n = 1'b1;
    step();
    pc("first_edge_blocked", {15'd0, a_busy}, 16'd0);
    step();
    pc("accept_rem", a_rem, 16'd4);
    pc("accept_ready", {15'd0, a_req_ready}, 16'd0);
    a_req_key = 16'h1234;
    for (int v = 3; v >= 0; v--) begin
      push(16'(v)); push(16'd0);
      step();
      chk("countdown_rem", a_rem);
      chk("countdown_reboot", {15'd0, a_reboot});
    end
    for (int i = 0; i < 20; i++) begin push(16'd1); push(16'd0); end
    for (int i = 0; i < 20; i++) begin
      step();
      chk("fire_reboot", {15'd0, a_reboot});
      chk("fire_rem", a_rem);
      if (i == 18) a_req_valid = 1'b0;
    end
    step();
    pc("post_fire_reboot", {15'd0, a_reboot}, 16'd0);
    pc("post_fire_busy", {15'd0, a_busy}, 16'd0);
    pc("post_fire_fail", {15'd0, a_fail}, 16'd1);
    pc("busy_req_ignored_bad", {8'd0, a_bad}, 16'd0);

    // bad keys, saturating at FF
    a_req_valid = 1'b1; a_req_key = 16'h1234;
    step();
    pc("bad_key_one", {8'd0, a_bad}, 16'd1);
    pc("bad_key_idle", {15'd0, a_busy}, 16'd0);
    repeat (299) step();
    pc("bad_key_sat", {8'd0, a_bad}, 16'h00FF);
    a_req_valid = 1'b0;

    // cancel at remaining==2
    a_req_valid = 1'b1; a_req_key = 16'hB007;
    step();
    a_req_valid = 1'b0;
    pc("cancel2_rem4", a_rem, 16'd4);
    repeat (2) step();
    pc("cancel2_rem2", a_rem, 16'd2);
    a_cancel = 1'b1;
    step();
    a_cancel = 1'b0;
    pc("cancel2_busy", {15'd0, a_busy}, 16'd0);
    pc("cancel2_rem", a_rem, 16'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      pc("cancel2_no_reboot", {15'd0, a_reboot}, 16'd0);
    end
    pc("fail_sticky", {15'd0, a_fail}, 16'd1);

    // cancel in the cycle where remaining==0
    a_req_valid = 1'b1;
    step();
    a_req_valid = 1'b0;
    repeat (4) step();
    pc("cancel0_rem0", a_rem, 16'd0);
    pc("cancel0_busy_before", {15'd0, a_busy}, 16'd1);
    a_cancel = 1'b1;
    step();
    a_cancel = 1'b0;
    pc("cancel0_busy", {15'd0, a_busy}, 16'd0);
    pc("cancel0_reboot", {15'd0, a_reboot}, 16'd0);
    step();
    pc("cancel0_reboot_later", {15'd0, a_reboot}, 16'd0);

    // cancel ignored in FIRE, then reset at FIRE cycle 5
    a_req_valid = 1'b1;
    step();
    a_req_valid = 1'b0;
    repeat (5) step();
    pc("fire_c1", {15'd0, a_reboot}, 16'd1);
    a_cancel = 1'b1;
    step();
    a_cancel = 1'b0;
    pc("fire_cancel_ignored", {15'd0, a_reboot}, 16'd1);
    pc("fire_cancel_busy", {15'd0, a_busy}, 16'd1);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    reset_vals_a();
    step();
    rst_n = 1'b1;
    step();

    // DELAY=0 instance: reboot one edge after acceptance; request during FIRE ignored
    b_req_valid = 1'b1; b_req_key = 16'hB007;
    step();
    pc("b_accept_busy", {15'd0, b_busy}, 16'd1);
    pc("b_accept_reboot", {15'd0, b_reboot}, 16'd0);
    b_req_key = 16'h1234;
    for (int i = 0; i < 20; i++) push(16'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("b_fire_reboot", {15'd0, b_reboot});
      if (i == 18) b_req_valid = 1'b0;
    end
    step();
    pc("b_end_reboot", {15'd0, b_reboot}, 16'd0);
    pc("b_end_fail", {15'd0, b_fail}, 16'd1);
    pc("b_fire_req_bad", {8'd0, b_bad}, 16'd0);
    pc("b_end_busy", {15'd0, b_busy}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
